// File: rtl/pipe_perf_monitor_if.sv
// pipe_perf_monitor_if: CPU event taps and counter readout
// for the pipeline performance monitor.
interface pipe_perf_monitor_if #(
  parameter int CNT_W = 32
);
  logic             start_i;
  logic             stall_i;
  logic             jump_i;
  logic             branch_i;
  logic             flush_i;
  logic [31:0]      pc_i;
  logic             clr_i;
  logic [CNT_W-1:0] cycle_o;
  logic [CNT_W-1:0] stall_cnt_o;
  logic [CNT_W-1:0] flush_cnt_o;
  logic             running_o;
  logic             done_o;
  logic             halt_o;
  logic [31:0]      last_pc_o;

  modport master (
    output start_i, stall_i, jump_i,
    output branch_i, flush_i, pc_i, clr_i,
    input  cycle_o, stall_cnt_o, flush_cnt_o,
    input  running_o, done_o, halt_o, last_pc_o
  );

  modport slave (
    input  start_i, stall_i, jump_i,
    input  branch_i, flush_i, pc_i, clr_i,
    output cycle_o, stall_cnt_o, flush_cnt_o,
    output running_o, done_o, halt_o, last_pc_o
  );
endinterface

// File: rtl/pipe_perf_monitor.sv
// pipe_perf_monitor: counts cycles, stalls and flushes of one
// CPU run; ends on cycle budget or on a PC that stops moving.
module pipe_perf_monitor #(
  parameter int CNT_W       = 32,
  parameter int MAX_CYCLES  = 30,
  parameter int IDLE_PC_LIM = 4
) (
  input logic clk_i,
  input logic rst_i,
  pipe_perf_monitor_if.slave mon
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Budget compare is done at >= 32 bits so a narrow counter
  // that saturates below MAX_CYCLES never fakes a budget hit.
  localparam int CW = (CNT_W > 32) ? CNT_W : 32;
  localparam int IW = $clog2(IDLE_PC_LIM + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [IW-1:0] IDLE_LIM = IW'(IDLE_PC_LIM);

  state_e state_q, state_d;

  logic             start_q, start_d;
  logic             armed_q, armed_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [CNT_W-1:0] stl_q, stl_d;
  logic [CNT_W-1:0] fls_q, fls_d;
  logic [IW-1:0]    idle_q, idle_d;
  logic             halt_q, halt_d;
  logic [31:0]      pc_prev_q, pc_prev_d;
  logic [31:0]      last_pc_q, last_pc_d;

  logic start_rise;
  logic clr_hit;
  logic stall_ok;
  logic pc_same;
  logic budget_hit;
  logic idle_hit;
  logic running;
  logic done;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  // Input qualification; armed_q blocks a start seen high
  // on the very first clock after reset.
  always_comb begin
    start_d    = mon.start_i;
    armed_d    = 1'b1;
    pc_prev_d  = mon.pc_i;
    start_rise = mon.start_i & ~start_q & armed_q;
    clr_hit    = (state_q == S_DONE) & mon.clr_i;
    stall_ok   = mon.stall_i & ~mon.jump_i & ~mon.branch_i;
    pc_same    = (mon.pc_i == pc_prev_q) & ~mon.stall_i;
  end

  // Event counters, idle detector and PC capture.
  always_comb begin
    cyc_d     = cyc_q;
    stl_d     = stl_q;
    fls_d     = fls_q;
    idle_d    = idle_q;
    halt_d    = halt_q;
    last_pc_d = last_pc_q;
    if (clr_hit) begin
      cyc_d  = '0;
      stl_d  = '0;
      fls_d  = '0;
      idle_d = '0;
      halt_d = 1'b0;
    end else if (running) begin
      cyc_d = sat_inc(cyc_q);
      if (stall_ok)
        stl_d = sat_inc(stl_q);
      if (mon.flush_i)
        fls_d = sat_inc(fls_q);
      if (!pc_same)
        idle_d = '0;
      else if (idle_q != IDLE_LIM)
        idle_d = idle_q + IW'(1);
      last_pc_d = mon.pc_i;
      if (idle_d == IDLE_LIM)
        halt_d = 1'b1;
    end
    idle_hit   = (idle_d == IDLE_LIM);
    budget_hit = (CW'(cyc_d) == CW'(MAX_CYCLES));
  end

  // Next-state logic of the run controller.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:
        if (start_rise)
          state_d = S_RUN;
      S_RUN:
        if (budget_hit || idle_hit)
          state_d = S_DONE;
      S_DONE:
        if (mon.clr_i)
          state_d = S_IDLE;
      default:
        state_d = S_IDLE;
    endcase
  end

  // State decode for the status outputs.
  always_comb begin
    running = 1'b0;
    done    = 1'b0;
    unique case (1'b1)
      (state_q == S_RUN):  running = 1'b1;
      (state_q == S_DONE): done    = 1'b1;
      default: ;
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= S_IDLE;
      start_q   <= 1'b0;
      armed_q   <= 1'b0;
      cyc_q     <= '0;
      stl_q     <= '0;
      fls_q     <= '0;
      idle_q    <= '0;
      halt_q    <= 1'b0;
      pc_prev_q <= '0;
      last_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      start_q   <= start_d;
      armed_q   <= armed_d;
      cyc_q     <= cyc_d;
      stl_q     <= stl_d;
      fls_q     <= fls_d;
      idle_q    <= idle_d;
      halt_q    <= halt_d;
      pc_prev_q <= pc_prev_d;
      last_pc_q <= last_pc_d;
    end
  end

  assign mon.cycle_o     = cyc_q;
  assign mon.stall_cnt_o = stl_q;
  assign mon.flush_cnt_o = fls_q;
  assign mon.running_o   = running;
  assign mon.done_o      = done;
  assign mon.halt_o      = halt_q;
  assign mon.last_pc_o   = last_pc_q;

endmodule

// File: tb/tb_pipe_perf_monitor.sv
// tb_pipe_perf_monitor: scoreboard bench for the run monitor,
// default build plus a 4-bit counter build.
`timescale 1ns/1ps
module tb_pipe_perf_monitor;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pipe_perf_monitor_if #(.CNT_W(32)) a ();
  pipe_perf_monitor_if #(.CNT_W(4))  b ();

  pipe_perf_monitor u_a (
    .clk_i (clk),
    .rst_i (rst_n),
    .mon   (a)
  );

  pipe_perf_monitor #(
    .CNT_W       (4),
    .MAX_CYCLES  (20),
    .IDLE_PC_LIM (4)
  ) u_b (
    .clk_i (clk),
    .rst_i (rst_n),
    .mon   (b)
  );

  typedef struct packed {
    logic [31:0] cyc;
    logic [31:0] stl;
    logic [31:0] fls;
    logic        halt;
    logic [31:0] pc;
  } exp_t;

  exp_t sb[$];
  int n_chk;
  int n_err;
  logic [31:0] pc_a;
  logic [31:0] pc_b;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic pop_cmp(input logic [31:0] cyc,
                         input logic [31:0] stl,
                         input logic [31:0] fls,
                         input logic        halt,
                         input logic [31:0] pc);
    exp_t e;
    chk("sb_has_entry", 64'(sb.size() > 0), 64'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("cycle_o", cyc, e.cyc);
      chk("stall_cnt_o", stl, e.stl);
      chk("flush_cnt_o", fls, e.fls);
      chk("halt_o", halt, e.halt);
      chk("last_pc_o", pc, e.pc);
    end
  endtask

  task automatic quiet_a();
    a.start_i  = 1'b0;
    a.stall_i  = 1'b0;
    a.jump_i   = 1'b0;
    a.branch_i = 1'b0;
    a.flush_i  = 1'b0;
    a.clr_i    = 1'b0;
  endtask

  task automatic step_pc_a();
    pc_a = pc_a + 32'd4;
    a.pc_i = pc_a;
  endtask

  // Called at a negedge; returns at the negedge after the
  // edge that enters RUN, with ps = PC of that start cycle.
  task automatic start_a(output logic [31:0] ps);
    a.start_i = 1'b0;
    step_pc_a();
    @(negedge clk);
    a.start_i = 1'b1;
    step_pc_a();
    @(negedge clk);
    ps = pc_a;
    chk("run_entered", a.running_o, 1);
  endtask

  task automatic hold_clear_a(input logic [31:0] cyc,
                              input logic [31:0] pc);
    a.start_i = 1'b0;
    a.clr_i   = 1'b0;
    @(negedge clk);
    a.start_i = 1'b1;
    @(negedge clk);
    chk("done_hold", a.done_o, 1);
    chk("cycle_hold", a.cycle_o, cyc);
    a.start_i = 1'b0;
    a.clr_i   = 1'b1;
    @(negedge clk);
    a.clr_i = 1'b0;
    chk("clr_done", a.done_o, 0);
    chk("clr_running", a.running_o, 0);
    chk("clr_cycle", a.cycle_o, 0);
    chk("clr_stall", a.stall_cnt_o, 0);
    chk("clr_flush", a.flush_cnt_o, 0);
    chk("clr_halt", a.halt_o, 0);
    chk("clr_pc_held", a.last_pc_o, pc);
  endtask

  // mode 0: plain run, start drops and clr pulses mid-run
  // mode 1: 3 clean stalls plus stalls masked by branch/jump
  // mode 2: stall and flush together for 2 cycles
  // fk != 0: PC frozen at 0x40 from RUN cycle fk
  task automatic run_a(input int mode, input int fk);
    logic [31:0] ps;
    exp_t e;
    bit seen;
    start_a(ps);
    e.stl  = (mode == 1) ? 32'd3 : (mode == 2) ? 32'd2 : 32'd0;
    e.fls  = (mode == 2) ? 32'd2 : 32'd0;
    e.halt = (fk != 0);
    if (fk != 0 && fk + 4 < 30)
      e.cyc = 32'(fk + 4);
    else
      e.cyc = 32'd30;
    e.pc = (fk != 0) ? 32'h40 : ps + 32'd120;
    sb.push_back(e);
    seen = 1'b0;
    for (int k = 1; k <= 40 && !seen; k++) begin
      quiet_a();
      a.start_i = (mode == 0 && k >= 5) ? 1'b0 : 1'b1;
      a.clr_i   = (mode == 0 && k == 8);
      if (mode == 1) begin
        a.stall_i  = (k >= 3 && k <= 5) || k == 7 || k == 9;
        a.branch_i = (k == 7);
        a.jump_i   = (k == 9);
      end
      if (mode == 2) begin
        a.stall_i = (k == 12 || k == 13);
        a.flush_i = (k == 12 || k == 13);
      end
      if (fk != 0 && k >= fk) begin
        pc_a   = 32'h40;
        a.pc_i = pc_a;
      end else begin
        step_pc_a();
      end
      @(negedge clk);
      seen = a.done_o;
    end
    quiet_a();
    chk("done_seen", 64'(seen), 64'd1);
    if (seen)
      pop_cmp(a.cycle_o, a.stall_cnt_o, a.flush_cnt_o,
              a.halt_o, a.last_pc_o);
    chk("run_left", a.running_o, 0);
    hold_clear_a(e.cyc, e.pc);
  endtask

  task automatic reset_mid_run();
    logic [31:0] ps;
    start_a(ps);
    for (int k = 1; k <= 12; k++) begin
      step_pc_a();
      @(negedge clk);
    end
    chk("pre_rst_cycle", a.cycle_o, 12);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_running", a.running_o, 0);
    chk("rst_done", a.done_o, 0);
    chk("rst_cycle", a.cycle_o, 0);
    chk("rst_last_pc", a.last_pc_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("no_restart_high", a.running_o, 0);
    a.start_i = 1'b0;
    @(negedge clk);
    a.start_i = 1'b1;
    @(negedge clk);
    chk("restart_toggle", a.running_o, 1);
    rst_n = 1'b0;
    a.start_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic narrow_run();
    exp_t e;
    bit seen;
    b.start_i = 1'b0;
    @(negedge clk);
    b.start_i = 1'b1;
    @(negedge clk);
    chk("b_run_entered", b.running_o, 1);
    for (int k = 1; k <= 25; k++) begin
      b.stall_i = 1'b1;
      pc_b = pc_b + 32'd4;
      b.pc_i = pc_b;
      @(negedge clk);
    end
    chk("b_still_running", b.running_o, 1);
    chk("b_cycle_sat", b.cycle_o, 15);
    chk("b_stall_sat", b.stall_cnt_o, 15);
    e.cyc  = 32'd15;
    e.stl  = 32'd15;
    e.fls  = 32'd0;
    e.halt = 1'b1;
    e.pc   = 32'h80;
    sb.push_back(e);
    b.stall_i = 1'b0;
    pc_b = 32'h80;
    b.pc_i = pc_b;
    seen = 1'b0;
    for (int k = 1; k <= 10 && !seen; k++) begin
      @(negedge clk);
      seen = b.done_o;
    end
    chk("b_done_seen", 64'(seen), 64'd1);
    if (seen)
      pop_cmp(32'(b.cycle_o), 32'(b.stall_cnt_o),
              32'(b.flush_cnt_o), b.halt_o, b.last_pc_o);
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    rst_n = 1'b0;
    quiet_a();
    a.start_i = 1'b1;
    pc_a = 32'h1000;
    a.pc_i = 32'h0;
    pc_b = 32'h2000;
    b.start_i  = 1'b0;
    b.stall_i  = 1'b0;
    b.jump_i   = 1'b0;
    b.branch_i = 1'b0;
    b.flush_i  = 1'b0;
    b.clr_i    = 1'b0;
    b.pc_i     = 32'h0;
    #1;
    chk("rst_state_running", a.running_o, 0);
    chk("rst_state_done", a.done_o, 0);
    chk("rst_state_cycle", a.cycle_o, 0);
    chk("rst_state_halt", a.halt_o, 0);
    chk("rst_state_pc", a.last_pc_o, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("no_start_from_reset", a.running_o, 0);
    run_a(0, 0);
    run_a(1, 0);
    run_a(2, 0);
    run_a(3, 10);
    run_a(4, 26);
    reset_mid_run();
    narrow_run();
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
